// File: rtl/hamming_decoder.sv
// Serial Hamming(136,128) receiver: deserialises p136..p1, corrects single-bit errors, presents 128 data bits.
// Optional saturating error counters enabled by defining HAMMING_DEC_ERRCNT_EN.
module hamming_decoder #(
  parameter int N    = 128,
  parameter int LEAD = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  input  logic         din,
  output logic [N:1]   dout,
  output logic         dout_valid,
  output logic         err_corrected,
  output logic         err_uncorrectable,
  output logic         frame_err,
  output logic [8:1]   syndrome,
  output logic         busy,
  output logic [15:0]  corr_cnt,
  output logic [15:0]  uncorr_cnt
);
  localparam int          CW       = N + 8;
  localparam logic [7:0]  CW_B     = 8'(CW);
  localparam logic [7:0]  LAST_CNT = 8'(CW - 1);
  localparam logic [7:0]  LEAD_M1  = 8'(LEAD - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SKIP    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CORRECT = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  logic [2:0]  state;
  logic [7:0]  cnt, lead_cnt, syn_acc, pos;
  logic [CW:1] cw, cw_fix;
  logic [N:1]  data_fix;
  logic        is_corr, is_uncorr;

  // Data bits occupy every non-power-of-two position, ascending.
  function automatic logic [N:1] extract(input logic [CW:1] c);
    logic [N:1] d;
    int k;
    d = '0;
    k = 1;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    end
    return d;
  endfunction

  assign pos       = CW_B - cnt;
  assign is_corr   = (syn_acc != 8'd0) && (syn_acc <= CW_B);
  assign is_uncorr = (syn_acc > CW_B);
  assign busy      = (state != S_IDLE);

  always_comb begin
    cw_fix = cw;
    if (is_corr) cw_fix[syn_acc] = ~cw[syn_acc];
    data_fix = extract(cw_fix);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      lead_cnt          <= '0;
      syn_acc           <= '0;
      cw                <= '0;
      dout              <= '0;
      dout_valid        <= 1'b0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
      frame_err         <= 1'b0;
      syndrome          <= '0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: if (sig_in) begin
          cnt      <= '0;
          syn_acc  <= '0;
          lead_cnt <= 8'd1;
          state    <= (LEAD == 1) ? S_SHIFT : S_SKIP;
        end
        S_SKIP: begin
          if (!sig_in) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            lead_cnt <= lead_cnt + 8'd1;
            if (lead_cnt == LEAD_M1) state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!sig_in) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cw[pos] <= din;
            if (din) syn_acc <= syn_acc ^ pos;
            cnt <= cnt + 8'd1;
            if (cnt == LAST_CNT) state <= S_CORRECT;
          end
        end
        S_CORRECT: begin
          syndrome          <= syn_acc;
          err_corrected     <= is_corr;
          err_uncorrectable <= is_uncorr;
          dout              <= data_fix;
          dout_valid        <= 1'b1;
          state             <= sig_in ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: if (!sig_in) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HAMMING_DEC_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (state == S_CORRECT) begin
      if (is_corr && corr_cnt != 16'hFFFF)     corr_cnt   <= corr_cnt + 16'd1;
      if (is_uncorr && uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
    end
  end
`else
  assign corr_cnt   = 16'h0000;
  assign uncorr_cnt = 16'h0000;
`endif

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Receive-side counterpart of the 128-bit Hamming encoder. Deserialises one 136-bit Hamming code word (128 data + 8 check bits, standard positional layout, no overall parity), computes the syndrome on the fly, corrects any single-bit error, and presents the 128 data bits in parallel with status flags. Sits directly on the encoder's serial link: `sig_in`/`din` connect to the encoder's `sig_out`/`dout`.

## Interface
- `N`, 128: data bits per frame (fixed; other values unsupported).
- `LEAD`, 1: lead slots discarded at frame start (encoder emits one idle slot with `sig_out` high before bit 136).
- `clk` input 1: clock; all sampling on posedge.
- `reset` input 1: asynchronous, active-low reset.
- `sig_in` input 1: frame envelope, high for `LEAD`+136 consecutive cycles.
- `din` input 1: serial code bit, code position 136 first, position 1 last.
- `dout` output 128 [128:1]: corrected data, held until next frame completes.
- `dout_valid` output 1: one-cycle pulse when `dout` updates.
- `err_corrected` output 1: frame had nonzero syndrome 1..136, bit flipped.
- `err_uncorrectable` output 1: syndrome 137..255; data passed uncorrected.
- `frame_err` output 1: one-cycle pulse, `sig_in` dropped early; frame discarded.
- `syndrome` output 8 [8:1]: syndrome of last completed frame.
- `busy` output 1: high in any state except IDLE.
- `corr_cnt`, `uncorr_cnt` output 16 each: frame counters (see Configuration).

## Operation
- Code position p (1..136): check bit k at p = 2^(k-1), k=1..8; data bits fill remaining positions ascending (`din[1]`→p3, `din[2..4]`→p5..7, `din[5..11]`→p9..15, `din[12..26]`→p17..31, `din[27..57]`→p33..63, `din[58..120]`→p65..127, `din[121..128]`→p129..136).
- States: IDLE, SKIP, SHIFT, CORRECT, DRAIN.
- IDLE: on posedge with `sig_in`=1 → SKIP (this sample counts as lead slot 1; with `LEAD`=1 go straight to SHIFT next). Clear bit counter and syndrome accumulator.
- SHIFT: each posedge with `sig_in`=1 stores `din` at position 136−cnt, cnt increments; if `din`=1, syndrome_acc ^= (136−cnt). After cnt reaches 135 sample → CORRECT.
- CORRECT (one cycle): syndrome ← syndrome_acc; if 1..136 flip that position, `err_corrected`=1; if ≥137 `err_uncorrectable`=1; if 0 both 0. Extract data into `dout`, pulse `dout_valid`. Bump counters. → DRAIN if `sig_in`=1, else IDLE.
- DRAIN: wait for `sig_in`=0, ignore `din`, then IDLE.
- `sig_in`=0 in SKIP or SHIFT: pulse `frame_err`, discard partial word, outputs `dout`/flags/`syndrome` unchanged, → IDLE.
- Flags `err_*` and `syndrome` hold until next CORRECT.

## Timing
- Reset: all outputs 0, state IDLE, counters 0; reset mid-frame aborts without `frame_err`.
- Latency: last code bit (p1) sampled at edge T; `dout`, flags, `syndrome`, `dout_valid` registered at edge T+1.
- Back-to-back frames: need ≥1 cycle `sig_in`=0 between frames (encoder always provides this).
- `busy` rises edge after first `sig_in`=1 sample, falls on return to IDLE.
- Counters saturate at 16'hFFFF.

## Configuration
- `HAMMING_DEC_ERRCNT_EN` defined: `corr_cnt` increments on each `err_corrected` frame, `uncorr_cnt` on each `err_uncorrectable` frame, saturating.
- Not defined: counter logic omitted; `corr_cnt` and `uncorr_cnt` tied to 16'h0000.

## Test plan
- Encoder→decoder loop, data 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 → `dout` equal, syndrome 0, both error flags 0, `dout_valid` one cycle after last bit.
- Same frame with position 3 (`din[1]`) inverted → syndrome 8'd3, `err_corrected`=1, `dout` equals original.
- Flip check bit p128 only → syndrome 8'd128, `err_corrected`=1, `dout` unchanged from original.
- Flip positions 129 and 8 → syndrome 8'd137, `err_uncorrectable`=1, `dout` carries corrupted `din[121]`, `uncorr_cnt`=1 with macro.
- Drop `sig_in` after 60 bits → `frame_err` pulse, `dout_valid` never asserts, previous `dout` retained; next clean frame decodes correctly.
- Assert `reset`=0 mid-frame at bit 70 → all outputs 0 immediately, IDLE; following full frame decodes with syndrome 0.
